// File: rtl/loop_expander.sv
// Loop-annotated instruction expander feeding the superscalar instruction queue.
// Optional perf counters are enabled by defining LOOP_EXPANDER_PERF_EN.
module loop_expander #(
  parameter int unsigned LANES     = 16,
  parameter int unsigned LOG_LANES = 4,
  parameter int unsigned ADDR_BITS = 18,
  parameter int unsigned ITER_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_type,
  input  logic [9:0]           in_arith,
  input  logic [8:0]           in_ram,
  input  logic [9:0]           in_ld_st,
  input  logic [ADDR_BITS-1:0] in_cache_addr,
  input  logic [ADDR_BITS-1:0] in_main_addr,
  input  logic [ADDR_BITS-1:0] in_d_cache,
  input  logic [ADDR_BITS-1:0] in_d_main,
  input  logic [ITER_BITS-1:0] in_iters,
  output logic                 iq_we,
  output logic [1:0]           iq_instr_type,
  output logic [LOG_LANES-1:0] iq_copy_count,
  output logic [ADDR_BITS-1:0] iq_cache_addr,
  output logic [ADDR_BITS-1:0] iq_main_mem_addr,
  output logic [ADDR_BITS-1:0] iq_d_cache_addr,
  output logic [ADDR_BITS-1:0] iq_d_main_mem_addr,
  output logic [9:0]           iq_arith,
  output logic [8:0]           iq_ram,
  output logic [9:0]           iq_ld_st,
  input  logic                 iq_empty,
  input  logic                 iq_needs_reset,
  output logic                 iq_reset,
  output logic                 busy
`ifdef LOOP_EXPANDER_PERF_EN
  ,
  output logic [31:0]          perf_pushes,
  output logic [31:0]          perf_stall_cycles,
  output logic [15:0]          perf_resyncs
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DRAIN, S_RESYNC} state_t;

  state_t               state_q, state_d;
  logic [ITER_BITS-1:0] rem_q, rem_d;
  logic [ADDR_BITS-1:0] acc_c_q, acc_c_d, acc_m_q, acc_m_d;
  logic [ADDR_BITS-1:0] step_c_q, step_c_d, step_m_q, step_m_d;
  logic                 settle_q, settle_d;
  logic                 in_ready_q, in_ready_d;
  logic                 busy_q, busy_d;
  logic                 iq_we_q, iq_we_d;
  logic                 iq_reset_q, iq_reset_d;
  logic [1:0]           type_q, type_d;
  logic [LOG_LANES-1:0] copy_q, copy_d;
  logic [ADDR_BITS-1:0] cache_q, cache_d, main_q, main_d;
  logic [ADDR_BITS-1:0] dc_q, dc_d, dm_q, dm_d;
  logic [9:0]           arith_q, arith_d, ldst_q, ldst_d;
  logic [8:0]           ram_q, ram_d;

  logic                 needs_rst;
  logic [ITER_BITS-1:0] chunk_src;
  logic [ITER_BITS-1:0] chunk_n;
  logic [ADDR_BITS-1:0] in_step_c, in_step_m;

  // The queue's needs_reset is unreliable while it settles after an iq_reset pulse.
  assign needs_rst = iq_needs_reset && !settle_q;
  assign in_ready  = in_ready_q && !needs_rst;

  assign chunk_src = (state_q == S_IDLE) ? in_iters : rem_q;
  assign chunk_n   = (chunk_src >= ITER_BITS'(LANES)) ? ITER_BITS'(LANES) : chunk_src;
  assign in_step_c = in_d_cache << LOG_LANES;
  assign in_step_m = in_d_main << LOG_LANES;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    acc_c_d    = acc_c_q;
    acc_m_d    = acc_m_q;
    step_c_d   = step_c_q;
    step_m_d   = step_m_q;
    settle_d   = 1'b0;
    iq_we_d    = 1'b0;
    iq_reset_d = 1'b0;
    type_d     = type_q;
    copy_d     = copy_q;
    cache_d    = cache_q;
    main_d     = main_q;
    dc_d       = dc_q;
    dm_d       = dm_q;
    arith_d    = arith_q;
    ram_d      = ram_q;
    ldst_d     = ldst_q;

    unique case (state_q)
      S_IDLE: begin
        if (needs_rst) begin
          state_d = S_DRAIN;
        end else if (in_valid && in_ready_q && in_iters != '0 && in_type != 2'd3) begin
          // First chunk is pushed straight from the inputs; accumulators hold chunk 1.
          type_d   = in_type;
          arith_d  = in_arith;
          ram_d    = in_ram;
          ldst_d   = in_ld_st;
          dc_d     = in_d_cache;
          dm_d     = in_d_main;
          step_c_d = in_step_c;
          step_m_d = in_step_m;
          iq_we_d  = 1'b1;
          copy_d   = LOG_LANES'(chunk_n - 1'b1);
          cache_d  = in_cache_addr;
          main_d   = in_main_addr;
          acc_c_d  = in_cache_addr + in_step_c;
          acc_m_d  = in_main_addr + in_step_m;
          rem_d    = in_iters - chunk_n;
          state_d  = S_EXPAND;
        end
      end
      S_EXPAND: begin
        if (rem_q == '0) begin
          state_d = S_IDLE;
        end else if (needs_rst) begin
          state_d = S_DRAIN;
        end else begin
          iq_we_d = 1'b1;
          copy_d  = LOG_LANES'(chunk_n - 1'b1);
          cache_d = acc_c_q;
          main_d  = acc_m_q;
          acc_c_d = acc_c_q + step_c_q;
          acc_m_d = acc_m_q + step_m_q;
          rem_d   = rem_q - chunk_n;
        end
      end
      S_DRAIN: begin
        if (iq_empty) begin
          iq_reset_d = 1'b1;
          state_d    = S_RESYNC;
        end
      end
      S_RESYNC: begin
        settle_d = 1'b1;
        state_d  = (rem_q != '0) ? S_EXPAND : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      acc_c_q    <= '0;
      acc_m_q    <= '0;
      step_c_q   <= '0;
      step_m_q   <= '0;
      settle_q   <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      iq_we_q    <= 1'b0;
      iq_reset_q <= 1'b0;
      type_q     <= '0;
      copy_q     <= '0;
      cache_q    <= '0;
      main_q     <= '0;
      dc_q       <= '0;
      dm_q       <= '0;
      arith_q    <= '0;
      ram_q      <= '0;
      ldst_q     <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      acc_c_q    <= acc_c_d;
      acc_m_q    <= acc_m_d;
      step_c_q   <= step_c_d;
      step_m_q   <= step_m_d;
      settle_q   <= settle_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      iq_we_q    <= iq_we_d;
      iq_reset_q <= iq_reset_d;
      type_q     <= type_d;
      copy_q     <= copy_d;
      cache_q    <= cache_d;
      main_q     <= main_d;
      dc_q       <= dc_d;
      dm_q       <= dm_d;
      arith_q    <= arith_d;
      ram_q      <= ram_d;
      ldst_q     <= ldst_d;
    end
  end

  assign iq_we              = iq_we_q;
  assign iq_reset           = iq_reset_q;
  assign busy               = busy_q;
  assign iq_instr_type      = type_q;
  assign iq_copy_count      = copy_q;
  assign iq_cache_addr      = cache_q;
  assign iq_main_mem_addr   = main_q;
  assign iq_d_cache_addr    = dc_q;
  assign iq_d_main_mem_addr = dm_q;
  assign iq_arith           = arith_q;
  assign iq_ram             = ram_q;
  assign iq_ld_st           = ldst_q;

`ifdef LOOP_EXPANDER_PERF_EN
  logic [31:0] pushes_q, pushes_d, stalls_q, stalls_d;
  logic [15:0] resyncs_q, resyncs_d;

  always_comb begin
    pushes_d  = pushes_q + {31'd0, iq_we_q};
    stalls_d  = stalls_q + {31'd0, (state_q == S_DRAIN || state_q == S_RESYNC)};
    resyncs_d = resyncs_q + {15'd0, iq_reset_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pushes_q  <= '0;
      stalls_q  <= '0;
      resyncs_q <= '0;
    end else begin
      pushes_q  <= pushes_d;
      stalls_q  <= stalls_d;
      resyncs_q <= resyncs_d;
    end
  end

  assign perf_pushes       = pushes_q;
  assign perf_stall_cycles = stalls_q;
  assign perf_resyncs      = resyncs_q;
`endif

endmodule

// File: tb/tb_loop_expander.sv
// Directed self-checking bench for loop_expander; perf checks enabled with LOOP_EXPANDER_PERF_EN.
module tb_loop_expander;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_type;
  logic [9:0]  in_arith;
  logic [8:0]  in_ram;
  logic [9:0]  in_ld_st;
  logic [17:0] in_cache_addr, in_main_addr, in_d_cache, in_d_main;
  logic [15:0] in_iters;
  logic        iq_we;
  logic [1:0]  iq_instr_type;
  logic [3:0]  iq_copy_count;
  logic [17:0] iq_cache_addr, iq_main_mem_addr, iq_d_cache_addr, iq_d_main_mem_addr;
  logic [9:0]  iq_arith, iq_ld_st;
  logic [8:0]  iq_ram;
  logic        iq_empty, iq_needs_reset, iq_reset, busy;
`ifdef LOOP_EXPANDER_PERF_EN
  logic [31:0] perf_pushes, perf_stall_cycles;
  logic [15:0] perf_resyncs;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  loop_expander #(.LANES(16), .LOG_LANES(4), .ADDR_BITS(18), .ITER_BITS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_arith(in_arith), .in_ram(in_ram), .in_ld_st(in_ld_st),
    .in_cache_addr(in_cache_addr), .in_main_addr(in_main_addr),
    .in_d_cache(in_d_cache), .in_d_main(in_d_main), .in_iters(in_iters),
    .iq_we(iq_we), .iq_instr_type(iq_instr_type), .iq_copy_count(iq_copy_count),
    .iq_cache_addr(iq_cache_addr), .iq_main_mem_addr(iq_main_mem_addr),
    .iq_d_cache_addr(iq_d_cache_addr), .iq_d_main_mem_addr(iq_d_main_mem_addr),
    .iq_arith(iq_arith), .iq_ram(iq_ram), .iq_ld_st(iq_ld_st),
    .iq_empty(iq_empty), .iq_needs_reset(iq_needs_reset), .iq_reset(iq_reset),
    .busy(busy)
`ifdef LOOP_EXPANDER_PERF_EN
    , .perf_pushes(perf_pushes), .perf_stall_cycles(perf_stall_cycles),
    .perf_resyncs(perf_resyncs)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ty, input logic [15:0] iters,
                       input logic [17:0] bc, input logic [17:0] dc,
                       input logic [17:0] bm, input logic [17:0] dm);
    in_type       = ty;
    in_iters      = iters;
    in_cache_addr = bc;
    in_d_cache    = dc;
    in_main_addr  = bm;
    in_d_main     = dm;
  endtask

  // Accepts one loop and checks every push against base + j*16*stride.
  task automatic run_loop(input logic [1:0] ty, input int unsigned iters,
                          input logic [17:0] bc, input logic [17:0] dc,
                          input logic [17:0] bm, input logic [17:0] dm);
    int unsigned np;
    int unsigned exp_copy;
    logic [17:0] exp_c, exp_m;
    np = (iters + 15) / 16;
    check("ready_pre", in_ready, 1);
    drive(ty, 16'(iters), bc, dc, bm, dm);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int unsigned j = 0; j < np; j++) begin
      exp_copy = (j == np - 1) ? (iters - 1) % 16 : 15;
      exp_c = 18'(32'(bc) + j * 16 * 32'(dc));
      exp_m = 18'(32'(bm) + j * 16 * 32'(dm));
      check("push_we", iq_we, 1);
      check("copy_count", iq_copy_count, exp_copy);
      check("cache_addr", iq_cache_addr, exp_c);
      check("main_addr", iq_main_mem_addr, exp_m);
      check("ready_busy", in_ready, 0);
      tick();
    end
    check("we_after", iq_we, 0);
    check("ready_after", in_ready, 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int unsigned cnt;
    logic [3:0]  last_copy;
    logic [17:0] last_addr;
    reset = 1'b1; in_valid = 1'b0; iq_empty = 1'b1; iq_needs_reset = 1'b0;
    in_arith = '0; in_ram = '0; in_ld_st = '0;
    drive(2'd0, '0, '0, '0, '0, '0);
    tick(); tick();
    check("rst_we", iq_we, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", in_ready, 0);
    check("rst_iq_reset", iq_reset, 0);
    check("rst_cache", iq_cache_addr, 0);
    reset = 1'b0;
    tick();
    check("ready_out_of_reset", in_ready, 1);

    in_arith = 10'h155; in_ram = 9'h0AA; in_ld_st = 10'h2C3;
    run_loop(2'd2, 40, 18'h00100, 18'd2, 18'h02000, 18'd3);
    check("type_pass", iq_instr_type, 2);
    check("arith_pass", iq_arith, 10'h155);
    check("ram_pass", iq_ram, 9'h0AA);
    check("ldst_pass", iq_ld_st, 10'h2C3);
    check("dcache_pass", iq_d_cache_addr, 2);
    check("dmain_pass", iq_d_main_mem_addr, 3);

    run_loop(2'd1, 16, 18'h00040, 18'd4, 18'h00000, 18'd1);
    run_loop(2'd0, 32, 18'h00000, 18'd0, 18'h3FFF0, 18'd1);

    // Zero-iteration and illegal-type instructions are swallowed
    drive(2'd2, 16'd0, 18'h1, 18'h1, 18'h1, 18'h1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("zero_we", iq_we, 0);
    check("zero_ready", in_ready, 1);
    check("zero_busy", busy, 0);
    drive(2'd3, 16'd5, 18'h1, 18'h1, 18'h1, 18'h1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("illegal_we", iq_we, 0);
    check("illegal_ready", in_ready, 1);

    // Back-to-back with in_valid held high
    drive(2'd2, 16'd20, 18'h00200, 18'd1, 18'h00000, 18'd0);
    in_valid = 1'b1;
    tick();
    check("b2b_p0_we", iq_we, 1);
    check("b2b_p0_copy", iq_copy_count, 15);
    tick();
    check("b2b_p1_we", iq_we, 1);
    check("b2b_p1_copy", iq_copy_count, 3);
    check("b2b_p1_addr", iq_cache_addr, 18'h00210);
    tick();
    check("b2b_gap_we", iq_we, 0);
    check("b2b_gap_ready", in_ready, 1);
    drive(2'd1, 16'd17, 18'h00800, 18'd1, 18'h00000, 18'd0);
    tick();
    in_valid = 1'b0;
    check("b2b_q0_we", iq_we, 1);
    check("b2b_q0_addr", iq_cache_addr, 18'h00800);
    check("b2b_q0_type", iq_instr_type, 1);
    tick();
    check("b2b_q1_copy", iq_copy_count, 0);
    check("b2b_q1_addr", iq_cache_addr, 18'h00810);
    tick();
    check("b2b_end_we", iq_we, 0);

    // Largest loop: 4096 pushes, last carries 15 copies
    drive(2'd2, 16'hFFFF, 18'h0, 18'd1, 18'h0, 18'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0; last_copy = '0; last_addr = '0;
    for (int unsigned c = 0; c < 5000 && iq_we; c++) begin
      cnt++;
      last_copy = iq_copy_count;
      last_addr = iq_cache_addr;
      tick();
    end
    check("max_pushes", cnt, 4096);
    check("max_last_copy", last_copy, 14);
    check("max_last_addr", last_addr, 18'h0FFF0);
    check("max_ready", in_ready, 1);

    // Reset in the middle of an expansion
    drive(2'd2, 16'd100, 18'h0, 18'd1, 18'h0, 18'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("midrst_we", iq_we, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("midrst_we2", iq_we, 0);
    check("midrst_ready", in_ready, 1);
    tick();
    check("midrst_we3", iq_we, 0);

    // Queue exhaustion before the second of three pushes
    drive(2'd2, 16'd40, 18'h00100, 18'd2, 18'h01000, 18'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("nr_p0_we", iq_we, 1);
    check("nr_p0_addr", iq_cache_addr, 18'h00100);
    iq_needs_reset = 1'b1;
    iq_empty = 1'b0;
    tick();
    for (int unsigned i = 0; i < 5; i++) begin
      check("nr_drain_we", iq_we, 0);
      check("nr_drain_rst", iq_reset, 0);
      check("nr_drain_busy", busy, 1);
      tick();
    end
    iq_empty = 1'b1;
    tick();
    check("nr_resync_rst", iq_reset, 1);
    check("nr_resync_we", iq_we, 0);
    iq_needs_reset = 1'b0;
    tick();
    check("nr_rst_single", iq_reset, 0);
    check("nr_settle_we", iq_we, 0);
    tick();
    check("nr_p1_we", iq_we, 1);
    check("nr_p1_copy", iq_copy_count, 15);
    check("nr_p1_addr", iq_cache_addr, 18'h00120);
    check("nr_p1_main", iq_main_mem_addr, 18'h01010);
    tick();
    check("nr_p2_we", iq_we, 1);
    check("nr_p2_copy", iq_copy_count, 7);
    check("nr_p2_addr", iq_cache_addr, 18'h00140);
    tick();
    check("nr_end_we", iq_we, 0);
    check("nr_end_ready", in_ready, 1);
`ifdef LOOP_EXPANDER_PERF_EN
    check("perf_pushes", perf_pushes, 3);
    check("perf_resyncs", perf_resyncs, 1);
    check("perf_stall_ge6", perf_stall_cycles >= 6, 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
